mem_bus_arbiter: RTL

- Parametrised N-master round-robin arbiter that shares one Memory port among several requesters: core instruction/data ports, DMA, debug.
- Sits between the masters and the Memory block; replaces direct core-to-memory wiring when more than one master is present.
- Holds the granted master's transaction until the memory acknowledges, then returns the response and the ack to that master only.

---
 rtl/mem_bus_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_MASTERS requesters.
// Optional BUSY watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_MASTERS-1:0]            m_rd_en_i,
  input  logic [NUM_MASTERS-1:0]            m_wr_en_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_i,
  output logic [DATA_WIDTH-1:0]             m_data_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic                              err_o,
  output logic [NUM_MASTERS-1:0]            grant_o,
  output logic                              mem_rd_en_o,
  output logic                              mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0]             mem_addr_o,
  output logic [DATA_WIDTH-1:0]             mem_data_o,
  input  logic [DATA_WIDTH-1:0]             mem_data_i,
  input  logic                              mem_ack_i
);

  localparam int          IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int          PAD_N = 1 << IDX_W;
  localparam int unsigned NM    = NUM_MASTERS;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [NUM_MASTERS-1:0] ack_q, ack_d;
  logic                   rd_q, rd_d;
  logic                   wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;

  // Request vectors padded to a power of two so any index value is in range.
  logic [PAD_N-1:0]       req_pad, wr_pad;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_found;

  always_comb begin
    req_pad = '0;
    wr_pad  = '0;
    req_pad[NUM_MASTERS-1:0] = m_rd_en_i | m_wr_en_i;
    wr_pad[NUM_MASTERS-1:0]  = m_wr_en_i;
  end

  always_comb begin
    int unsigned      c;
    logic [IDX_W-1:0] cand;
    win_idx   = last_q;
    win_found = 1'b0;
    c         = 0;
    cand      = '0;
    for (int unsigned i = 1; i <= NM; i++) begin
      c = 32'(last_q) + i;
      if (c >= NM) c = c - NM;
      cand = IDX_W'(c);
      if (!win_found && req_pad[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    ack_d   = '0;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          last_d  = win_idx;
          grant_d = NUM_MASTERS'(1) << win_idx;
          wr_d    = wr_pad[win_idx];
          rd_d    = !wr_pad[win_idx];
          addr_d  = m_addr_i[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = m_data_i[win_idx*DATA_WIDTH +: DATA_WIDTH];
          state_d = BUSY;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          if (!wr_q) rdata_d = mem_data_i;
          ack_d   = grant_q;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = RESP;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = '0;
          ack_d   = grant_q;
          err_d   = 1'b1;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(NUM_MASTERS - 1);
      grant_q <= '0;
      ack_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign m_data_o    = rdata_q;
  assign m_ack_o     = ack_q;
  assign grant_o     = grant_q;
  assign mem_rd_en_o = rd_q;
  assign mem_wr_en_o = wr_q;
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = wdata_q;
`ifdef ARB_TIMEOUT_EN
  assign err_o       = err_q;
`else
  assign err_o       = 1'b0;
`endif

endmodule
